// File: rtl/bcd_mod_counter_if.sv
// Control/data bundle for one counting stage of the digital clock.
// The stage owns dout/co/load_err; the driver owns everything else.
interface bcd_mod_counter_if #(
    parameter int DIGITS = 2
);
    logic                  en;
    logic                  cnt_in;
    logic                  adjust;
    logic                  dir;
    logic                  load;
    logic [4*DIGITS-1:0]   load_bcd;
    logic [4*DIGITS-1:0]   dout;
    logic                  co;
    logic                  load_err;

    modport master (
        output en, cnt_in, adjust, dir, load, load_bcd,
        input  dout, co, load_err
    );

    modport slave (
        input  en, cnt_in, adjust, dir, load, load_bcd,
        output dout, co, load_err
    );
endinterface

// File: rtl/bcd_mod_counter.sv
// N-digit BCD counter over [MIN_VAL, MAX_VAL] with up/down stepping,
// parallel load and a registered carry/borrow pulse for chaining stages.
module bcd_mod_counter #(
    parameter int DIGITS  = 2,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_mod_counter_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int unsigned v);
        logic [W-1:0] r;
        int unsigned  t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t           = t / 10;
        end
        return r;
    endfunction

    // Valid BCD words order the same way as the numbers they encode,
    // so a plain unsigned compare is a correct decimal compare.
    function automatic logic bcd_ge(input logic [W-1:0] a, input logic [W-1:0] b);
        return a >= b;
    endfunction

    function automatic logic is_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VAL);
    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

    logic [W-1:0] dout_q, dout_d;
    logic         co_q, co_d;
    logic         err_q, err_d;

    logic [W-1:0] inc_val, dec_val;
    logic         carry, borrow;
    logic         cur_ok, load_ok, step, wrap;

    // NOTE: carry/borrow are ripple temporaries inside one evaluation, so
    // they use blocking assignments and get a default before the loop.
    always_comb begin
        inc_val = dout_q;
        dec_val = dout_q;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (dout_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = dout_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
            if (borrow) begin
                if (dout_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = dout_q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    always_comb begin
        cur_ok  = is_bcd(dout_q) && bcd_ge(dout_q, MIN_BCD) && bcd_ge(MAX_BCD, dout_q);
        load_ok = is_bcd(bus.load_bcd) && bcd_ge(bus.load_bcd, MIN_BCD)
                  && bcd_ge(MAX_BCD, bus.load_bcd);
        step    = bus.cnt_in | bus.adjust;

        dout_d  = dout_q;
        wrap    = 1'b0;
        err_d   = 1'b0;

        if (bus.load) begin
            if (load_ok) dout_d = bus.load_bcd;
            else         err_d  = 1'b1;
        end else if (bus.en && step) begin
            if (!cur_ok) begin
                // Corrupted state recovers to the bottom of the range.
                dout_d = MIN_BCD;
            end else if (bus.dir) begin
                if (dout_q == MAX_BCD) begin
                    dout_d = MIN_BCD;
                    wrap   = 1'b1;
                end else begin
                    dout_d = inc_val;
                end
            end else begin
                if (dout_q == MIN_BCD) begin
                    dout_d = MAX_BCD;
                    wrap   = 1'b1;
                end else begin
                    dout_d = dec_val;
                end
            end
        end

        // Manual adjust alone never ripples into the next stage.
        co_d = wrap & bus.cnt_in;
    end

    // NOTE: state registers use non-blocking assignments and reset
    // asynchronously, so the count clears without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= MIN_BCD;
            co_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            co_q   <= co_d;
            err_q  <= err_d;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.co       = co_q;
    assign bus.load_err = err_q;
endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for three counter instances (0..23, 1..12, 0..999); expected
// results are queued when stimulus is driven and compared after the edge.
module tb_bcd_mod_counter;
    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int          unit;
        logic [11:0] dout;
        logic        co;
        logic        err;
    } exp_t;

    exp_t sb[$];

    bcd_mod_counter_if #(.DIGITS(2)) if0 ();
    bcd_mod_counter_if #(.DIGITS(2)) if1 ();
    bcd_mod_counter_if #(.DIGITS(3)) if2 ();

    bcd_mod_counter #(.DIGITS(2), .MIN_VAL(0), .MAX_VAL(23))  u_hours24 (.clk(clk), .rst_n(rst_n), .bus(if0));
    bcd_mod_counter #(.DIGITS(2), .MIN_VAL(1), .MAX_VAL(12))  u_hours12 (.clk(clk), .rst_n(rst_n), .bus(if1));
    bcd_mod_counter #(.DIGITS(3), .MIN_VAL(0), .MAX_VAL(999)) u_three   (.clk(clk), .rst_n(rst_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] bcd(input int n);
        return 12'(((n / 100) << 8) | (((n / 10) % 10) << 4) | (n % 10));
    endfunction

    function automatic logic [13:0] obs(input int unit);
        case (unit)
            0:       return {4'h0, if0.dout, if0.co, if0.load_err};
            1:       return {4'h0, if1.dout, if1.co, if1.load_err};
            default: return {if2.dout, if2.co, if2.load_err};
        endcase
    endfunction

    task automatic push(input string tag, input int unit, input logic [11:0] d,
                        input logic co, input logic err);
        exp_t e;
        e.tag  = tag;
        e.unit = unit;
        e.dout = d;
        e.co   = co;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic check_pending();
        exp_t        e;
        logic [13:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.unit);
            checks++;
            assert (o === {e.dout, e.co, e.err}) else begin
                errors++;
                $error("FAIL %s: dout/co/load_err got %h/%b/%b expected %h/%b/%b",
                       e.tag, o[13:2], o[1], o[0], e.dout, e.co, e.err);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_pending();
    endtask

    initial begin
        rst_n = 1'b0;
        {if0.en, if0.cnt_in, if0.adjust, if0.dir, if0.load} = 5'b10010;
        {if1.en, if1.cnt_in, if1.adjust, if1.dir, if1.load} = 5'b10010;
        {if2.en, if2.cnt_in, if2.adjust, if2.dir, if2.load} = 5'b10010;
        if0.load_bcd = '0;
        if1.load_bcd = '0;
        if2.load_bcd = '0;

        repeat (2) @(posedge clk);
        #1;
        push("reset_u24", 0, 12'h000, 1'b0, 1'b0);
        push("reset_u12", 1, 12'h001, 1'b0, 1'b0);
        push("reset_u999", 2, 12'h000, 1'b0, 1'b0);
        check_pending();
        rst_n = 1'b1;

        // 0..23 instance: down wrap, up wrap back, then a full up sweep.
        if0.dir = 1'b0; if0.cnt_in = 1'b1;
        push("u24_down_wrap", 0, 12'h023, 1'b1, 1'b0);
        tick();
        if0.dir = 1'b1;
        push("u24_up_wrap_back", 0, 12'h000, 1'b1, 1'b0);
        tick();
        for (int i = 1; i <= 23; i++) begin
            push($sformatf("u24_up_to_%0d", i), 0, bcd(i), 1'b0, 1'b0);
            tick();
        end
        push("u24_wrap_23_to_00", 0, 12'h000, 1'b1, 1'b0);
        tick();
        if0.cnt_in = 1'b0;
        push("u24_co_one_cycle", 0, 12'h000, 1'b0, 1'b0);
        tick();

        if0.load = 1'b1; if0.load_bcd = 8'h23;
        push("u24_load_23", 0, 12'h023, 1'b0, 1'b0);
        tick();
        if0.load = 1'b0; if0.adjust = 1'b1;
        push("u24_adjust_wrap_no_co", 0, 12'h000, 1'b0, 1'b0);
        tick();
        if0.cnt_in = 1'b1;
        push("u24_cnt_and_adjust_one_step", 0, 12'h001, 1'b0, 1'b0);
        tick();
        if0.adjust = 1'b0; if0.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push($sformatf("u24_en_low_hold_%0d", i), 0, 12'h001, 1'b0, 1'b0);
            tick();
        end
        if0.load = 1'b1; if0.load_bcd = 8'h17;
        push("u24_load_17_en_low", 0, 12'h017, 1'b0, 1'b0);
        tick();
        if0.en = 1'b1; if0.load_bcd = 8'h2A;
        push("u24_load_2A_rejected", 0, 12'h017, 1'b0, 1'b1);
        tick();
        if0.load_bcd = 8'h24;
        push("u24_load_24_rejected", 0, 12'h017, 1'b0, 1'b1);
        tick();
        if0.load = 1'b0; if0.cnt_in = 1'b0;
        push("u24_load_err_one_cycle", 0, 12'h017, 1'b0, 1'b0);
        tick();

        // 1..12 instance.
        if1.dir = 1'b0; if1.cnt_in = 1'b1;
        push("u12_down_wrap", 1, 12'h012, 1'b1, 1'b0);
        tick();
        push("u12_down_12_to_11", 1, 12'h011, 1'b0, 1'b0);
        tick();
        if1.dir = 1'b1;
        push("u12_up_11_to_12", 1, 12'h012, 1'b0, 1'b0);
        tick();
        push("u12_up_wrap", 1, 12'h001, 1'b1, 1'b0);
        tick();
        if1.cnt_in = 1'b0; if1.adjust = 1'b1; if1.dir = 1'b0;
        push("u12_adjust_down_wrap_no_co", 1, 12'h012, 1'b0, 1'b0);
        tick();
        if1.adjust = 1'b0; if1.load = 1'b1; if1.load_bcd = 8'h00;
        push("u12_load_below_min", 1, 12'h012, 1'b0, 1'b1);
        tick();
        if1.load = 1'b0;

        // 0..999 instance.
        if2.load = 1'b1; if2.load_bcd = 12'h099;
        push("u999_load_099", 2, 12'h099, 1'b0, 1'b0);
        tick();
        if2.load = 1'b0; if2.cnt_in = 1'b1;
        push("u999_099_to_100", 2, 12'h100, 1'b0, 1'b0);
        tick();
        if2.dir = 1'b0;
        push("u999_down_100_to_099", 2, 12'h099, 1'b0, 1'b0);
        tick();
        if2.cnt_in = 1'b0; if2.dir = 1'b1; if2.load = 1'b1; if2.load_bcd = 12'h999;
        push("u999_load_999", 2, 12'h999, 1'b0, 1'b0);
        tick();
        if2.load = 1'b0; if2.cnt_in = 1'b1;
        push("u999_wrap_to_000", 2, 12'h000, 1'b1, 1'b0);
        tick();
        if2.cnt_in = 1'b0; if2.load = 1'b1; if2.load_bcd = 12'h0A0;
        push("u999_load_nonbcd", 2, 12'h000, 1'b0, 1'b1);
        tick();
        if2.load = 1'b0;

        // Asynchronous reset while the 0..23 stage is counting.
        if0.load = 1'b1; if0.load_bcd = 8'h14;
        push("u24_load_14", 0, 12'h014, 1'b0, 1'b0);
        tick();
        if0.load = 1'b0; if0.cnt_in = 1'b1;
        push("u24_count_to_15", 0, 12'h015, 1'b0, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        push("u24_async_reset", 0, 12'h000, 1'b0, 1'b0);
        push("u12_async_reset", 1, 12'h001, 1'b0, 1'b0);
        check_pending();
        rst_n = 1'b1;
        if0.cnt_in = 1'b0;
        push("u24_after_reset_idle", 0, 12'h000, 1'b0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
